// File: rtl/viterbi_input_fifo.sv
// Input staging buffer for the Viterbi decoder: a DEPTH-entry circular FIFO of
// code-symbol frames feeding a single decode slot that advances on refresh.
module viterbi_input_fifo #(
  parameter int N_PAIRS = 8,
  parameter int PAIR_W  = 2,
  parameter int DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [N_PAIRS*PAIR_W-1:0]         in_data,
  output logic                              in_ready,
  input  logic                              refresh,
  input  logic                              flush,
  output logic [N_PAIRS*PAIR_W-1:0]         sym_out,
  output logic                              frame_valid,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic                              overflow
);

  localparam int DATA_W = N_PAIRS * PAIR_W;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              wr;
  logic              slot_open;
  logic              fifo_empty;
  logic              pop;
  logic              bypass;
  logic              fifo_wr;
  logic [LVL_W-1:0]  level_next;

  // in_ready deliberately ignores a same-cycle pop to keep it off the refresh path.
  assign in_ready   = (level != LVL_W'(DEPTH));
  assign wr         = in_valid && in_ready;
  assign slot_open  = !frame_valid || refresh;
  assign fifo_empty = (level == '0);
  assign pop        = slot_open && !fifo_empty;
  assign bypass     = slot_open && fifo_empty && wr;
  assign fifo_wr    = wr && !bypass;

  always_comb begin
    level_next = level;
    case ({fifo_wr, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      sym_out     <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      sym_out     <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      level <= level_next;
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      if (slot_open) begin
        if (pop) begin
          sym_out     <= mem[rd_ptr];
          rd_ptr      <= rd_ptr + PTR_W'(1);
          frame_valid <= 1'b1;
        end else if (bypass) begin
          sym_out     <= in_data;
          frame_valid <= 1'b1;
        end else begin
          frame_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_input_fifo.sv
// Self-checking bench for viterbi_input_fifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_viterbi_input_fifo;

  localparam int N_PAIRS = 8;
  localparam int PAIR_W  = 2;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = N_PAIRS * PAIR_W;
  localparam int LVL_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              refresh;
  logic              flush;
  logic [DATA_W-1:0] sym_out;
  logic              frame_valid;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_slot;
  bit                m_fv;
  bit                m_ovf;

  viterbi_input_fifo #(.N_PAIRS(N_PAIRS), .PAIR_W(PAIR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .refresh(refresh), .flush(flush), .sym_out(sym_out),
    .frame_valid(frame_valid), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_slot = '0;
    m_fv   = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    bit ready;
    bit accept;
    ready  = (mq.size() != DEPTH);
    accept = v && ready;
    if (f) begin
      model_clear();
    end else begin
      if (v && !ready) m_ovf = 1'b1;
      if (!m_fv || r) begin
        if (mq.size() > 0) begin
          m_slot = mq.pop_front();
          m_fv   = 1'b1;
          if (accept) mq.push_back(d);
        end else if (accept) begin
          m_slot = d;
          m_fv   = 1'b1;
        end else begin
          m_fv = 1'b0;
        end
      end else if (accept) begin
        mq.push_back(d);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".sym_out"},     sym_out,     m_slot);
    chk({tag, ".frame_valid"}, frame_valid, m_fv);
    chk({tag, ".level"},       level,       mq.size());
    chk({tag, ".overflow"},    overflow,    m_ovf);
  endtask

  // Called just after a rising edge; drives, checks in_ready, advances one clock.
  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    in_valid = v;
    in_data  = d;
    refresh  = r;
    flush    = f;
    #1;
    chk("in_ready", in_ready, (mq.size() != DEPTH));
    @(posedge clk);
    model_step(v, d, r, f);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    logic [DATA_W-1:0] seen[$];
    logic [DATA_W-1:0] last;
    int                nxt;
    bit                v;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; refresh = 1'b0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.level", level, 0);
    chk("rst.frame_valid", frame_valid, 0);
    chk("rst.sym_out", sym_out, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.in_ready", in_ready, 1);
    rst = 1'b0;

    // zero frame goes straight to the slot
    cyc(1, 16'h0000, 0, 0);
    chk("zero.fv", frame_valid, 1);
    chk("zero.sym", sym_out, 16'h0000);
    chk("zero.level", level, 0);

    // back-to-back writes then drain
    cyc(0, 0, 0, 1);
    cyc(1, 16'hA5A5, 0, 0);
    cyc(1, 16'h1234, 0, 0);
    cyc(1, 16'h00FF, 0, 0);
    chk("b2b.slot", sym_out, 16'hA5A5);
    chk("b2b.level", level, 2);
    cyc(0, 0, 1, 0);
    chk("drain1", sym_out, 16'h1234);
    cyc(0, 0, 1, 0);
    chk("drain2", sym_out, 16'h00FF);
    cyc(0, 0, 1, 0);
    chk("drain3.fv", frame_valid, 0);
    chk("drain3.hold", sym_out, 16'h00FF);

    // fill, overflow, refresh, then flush with everything asserted
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 16'hF000 + 16'(i), 0, 0);
    chk("full.level", level, 4);
    chk("full.in_ready", in_ready, 0);
    cyc(1, 16'hF005, 0, 0);
    chk("ovf.flag", overflow, 1);
    chk("ovf.level", level, 4);
    cyc(0, 0, 1, 0);
    chk("ovf_ref.level", level, 3);
    chk("ovf_ref.in_ready", in_ready, 1);
    chk("ovf_ref.flag", overflow, 1);
    chk("ovf_ref.slot", sym_out, 16'hF001);
    cyc(1, 16'hBEEF, 1, 1);
    chk("flush.level", level, 0);
    chk("flush.fv", frame_valid, 0);
    chk("flush.ovf", overflow, 0);
    chk("flush.in_ready", in_ready, 1);
    chk("flush.sym", sym_out, 0);

    // simultaneous write and pop at level 2
    cyc(1, 16'h0011, 0, 0);
    cyc(1, 16'h0022, 0, 0);
    cyc(1, 16'h0033, 0, 0);
    chk("wp.pre_level", level, 2);
    cyc(1, 16'h0044, 1, 0);
    chk("wp.level", level, 2);
    chk("wp.slot", sym_out, 16'h0022);
    cyc(0, 0, 1, 0);
    chk("wp.r1", sym_out, 16'h0033);
    cyc(0, 0, 1, 0);
    chk("wp.r2", sym_out, 16'h0044);

    // wrap-around stream of 10 distinct frames
    cyc(0, 0, 0, 1);
    nxt  = 1;
    last = '0;
    for (int i = 0; i < 40; i++) begin
      v = (nxt <= 10) && (mq.size() != DEPTH);
      cyc(v, DATA_W'(nxt), (i % 2) == 1, 0);
      if (v) nxt++;
      if (frame_valid && sym_out != last) begin
        seen.push_back(sym_out);
        last = sym_out;
      end
    end
    chk("wrap.count", seen.size(), 10);
    for (int k = 0; k < seen.size(); k++) chk("wrap.order", seen[k], k + 1);
    chk("wrap.ovf", overflow, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 6), DATA_W'($urandom), ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 99) < 3));
    end

    // async reset mid-stream
    cyc(1, 16'h5A5A, 0, 0);
    cyc(1, 16'h6B6B, 0, 0);
    cyc(1, 16'h7C7C, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.level", level, 0);
    chk("arst.fv", frame_valid, 0);
    chk("arst.ovf", overflow, 0);
    chk("arst.sym", sym_out, 0);
    chk("arst.in_ready", in_ready, 1);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 16'h1357, 0, 0);
    chk("post_rst.sym", sym_out, 16'h1357);
    cyc(1, 16'h2468, 0, 0);
    cyc(0, 0, 1, 0);
    chk("post_rst.r", sym_out, 16'h2468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
